rv_bank_req_scheduler: RTL



---
 rtl/rv_bank_req_scheduler.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rv_bank_req_scheduler.sv
// Per-bank round-robin request scheduler with one registered valid/ready output stage per bank.
// Define RV_BANK_SCHED_STATS_EN to add the saturating conflict_cnt output.
module rv_bank_req_scheduler #(
    parameter int NUM_REQS     = 4,
    parameter int NUM_BANKS    = 4,
    parameter int ADDR_W       = 8,
    parameter int BANK_SEL_POS = 2,
    parameter int TAG_W        = 4,
    localparam int BANK_BITS   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
    localparam int BADDR_W     = ADDR_W - BANK_BITS,
    localparam int REQ_IDX_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            req_valid,
    input  logic [NUM_REQS*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQS*TAG_W-1:0]      req_tag,
    output logic [NUM_REQS-1:0]            req_ready,
    output logic [NUM_BANKS-1:0]           bank_valid,
    output logic [NUM_BANKS*BADDR_W-1:0]   bank_addr,
    output logic [NUM_BANKS*TAG_W-1:0]     bank_tag,
    output logic [NUM_BANKS*REQ_IDX_W-1:0] bank_req_idx,
    input  logic [NUM_BANKS-1:0]           bank_ready
`ifdef RV_BANK_SCHED_STATS_EN
    ,
    output logic [31:0]                    conflict_cnt
`endif
);

    localparam int BSW = (BANK_BITS > 0) ? BANK_BITS : 1;

    logic [BSW-1:0]       req_bank  [NUM_REQS];
    logic [BADDR_W-1:0]   req_baddr [NUM_REQS];

    logic [REQ_IDX_W-1:0] rr         [NUM_BANKS];
    logic [REQ_IDX_W-1:0] grant_idx  [NUM_BANKS];
    logic [BADDR_W-1:0]   grant_addr [NUM_BANKS];
    logic [TAG_W-1:0]     grant_tag  [NUM_BANKS];
    logic [NUM_BANKS-1:0] grant_vld;
    logic [NUM_BANKS-1:0] can_load;
    logic [NUM_BANKS-1:0] accept;

    // Split each address into bank select and bank-local address; edge positions need their own slices.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_decode
        logic [ADDR_W-1:0] a;
        assign a = req_addr[i*ADDR_W +: ADDR_W];
        if (NUM_BANKS == 1) begin : g_one
            assign req_bank[i]  = '0;
            assign req_baddr[i] = a;
        end else if (BANK_SEL_POS == 0) begin : g_lsb
            assign req_bank[i]  = a[BANK_BITS-1:0];
            assign req_baddr[i] = a[ADDR_W-1:BANK_BITS];
        end else if (BANK_SEL_POS == BADDR_W) begin : g_msb
            assign req_bank[i]  = a[ADDR_W-1:BADDR_W];
            assign req_baddr[i] = a[BADDR_W-1:0];
        end else begin : g_mid
            assign req_bank[i]  = a[BANK_SEL_POS +: BANK_BITS];
            assign req_baddr[i] = {a[ADDR_W-1:BANK_SEL_POS+BANK_BITS], a[BANK_SEL_POS-1:0]};
        end
    end

    // Scan from the highest offset down so the lowest offset from rr is the one that sticks.
    always_comb begin
        int j;
        j         = 0;
        req_ready = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            grant_vld[b]  = 1'b0;
            grant_idx[b]  = '0;
            grant_addr[b] = '0;
            grant_tag[b]  = '0;
            can_load[b]   = !bank_valid[b] || bank_ready[b];
            for (int k = NUM_REQS - 1; k >= 0; k--) begin
                j = int'(rr[b]) + k;
                if (j >= NUM_REQS) j = j - NUM_REQS;
                if (req_valid[j] && (req_bank[j] == BSW'(b))) begin
                    grant_vld[b]  = 1'b1;
                    grant_idx[b]  = REQ_IDX_W'(j);
                    grant_addr[b] = req_baddr[j];
                    grant_tag[b]  = req_tag[j*TAG_W +: TAG_W];
                end
            end
            accept[b] = grant_vld[b] && can_load[b];
            if (accept[b]) req_ready[grant_idx[b]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_valid   <= '0;
            bank_addr    <= '0;
            bank_tag     <= '0;
            bank_req_idx <= '0;
            for (int b = 0; b < NUM_BANKS; b++) rr[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (accept[b]) begin
                    bank_valid[b]                            <= 1'b1;
                    bank_addr[b*BADDR_W +: BADDR_W]          <= grant_addr[b];
                    bank_tag[b*TAG_W +: TAG_W]               <= grant_tag[b];
                    bank_req_idx[b*REQ_IDX_W +: REQ_IDX_W]   <= grant_idx[b];
                    rr[b] <= (int'(grant_idx[b]) == NUM_REQS - 1) ? '0 : grant_idx[b] + 1'b1;
                end else if (bank_ready[b]) begin
                    bank_valid[b] <= 1'b0;
                end
            end
        end
    end

`ifdef RV_BANK_SCHED_STATS_EN
    // Counts cycles where some valid requester was left waiting; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (|(req_valid & ~req_ready) && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule
